// File: rtl/layer_reg_file.sv
// Layer-header register file: masked writes, registered write-first read ports,
// per-entry dirty flags and a sequenced soft-clear sweep.
module layer_reg_file #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       DEPTH    = 32,
  parameter int unsigned       ADDR_W   = 5,
  parameter int unsigned       NUM_RD   = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          wr_mask,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       clr_done,
  output logic                       wr_drop,
  output logic [DEPTH-1:0]           dirty,
  input  logic                       dirty_clr,
  output logic                       dirty_any
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DEPTH-1:0]    dirty_q, dirty_d;
  logic                clr_done_q, clr_done_d;
  logic                wr_drop_q, wr_drop_d;

  logic                wr_valid;
  logic                wr_acc;
  logic                wr_set;
  logic                sweep_we;
  logic                sweep_last;
  logic [DATA_W-1:0]   wr_cur;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Out-of-range writes are silently ignored: they never reach accept or drop logic.
  assign wr_valid   = wr_en && (32'(wr_addr) < DEPTH);
  assign sweep_last = (idx_q == ADDR_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_req)    state_d = ST_CLEAR;
      ST_CLEAR: if (sweep_last) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: sweep control, write acceptance and drop reporting; clear beats writes
  always_comb begin
    sweep_we   = 1'b0;
    wr_acc     = 1'b0;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    wr_drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          idx_d     = '0;
          wr_drop_d = wr_valid;
        end else begin
          wr_acc = wr_valid;
        end
      end
      ST_CLEAR: begin
        sweep_we  = 1'b1;
        wr_drop_d = wr_valid;
        if (sweep_last) begin
          idx_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      dirty_q    <= '0;
    end else begin
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
      dirty_q    <= dirty_d;
    end
  end

  // Current contents of the write target, merged with the masked write data
  always_comb begin
    wr_cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_cur = mem[i];
    end
  end

  assign wr_merged = (wr_cur & ~wr_mask) | (wr_data & wr_mask);
  assign wr_set    = wr_acc && (wr_mask != '0);

  // Dirty flags: a same-cycle accepted write overrides the bulk clear
  always_comb begin
    dirty_d = dirty_q;
    if (dirty_clr) dirty_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sweep_we && (idx_q == ADDR_W'(i))) dirty_d[i] = 1'b0;
      if (wr_set && (wr_addr == ADDR_W'(i))) dirty_d[i] = 1'b1;
    end
  end

  // Storage entries
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [DATA_W-1:0] ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (sweep_we && (idx_q == ADDR_W'(i))) begin
        ent_d = INIT_VAL;
      end else if (wr_acc && (wr_addr == ADDR_W'(i))) begin
        ent_d = wr_merged;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ent_q <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end

    assign mem[i] = ent_q;
  end

  // Registered read ports with write-first bypass of the write and the sweep
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    logic [DATA_W-1:0] rd_q, rd_d;

    assign ra = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      rv = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (ra == ADDR_W'(i)) rv = mem[i];
      end
      if (wr_acc && (wr_addr == ra)) rv = wr_merged;
      if (sweep_we && (idx_q == ra)) rv = INIT_VAL;
    end

    assign rd_d = rd_en[p] ? rv : rd_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = rd_q;
  end

  assign busy      = (state_q == ST_CLEAR);
  assign clr_done  = clr_done_q;
  assign wr_drop   = wr_drop_q;
  assign dirty     = dirty_q;
  assign dirty_any = |dirty_q;

endmodule

// File: tb/tb_layer_reg_file.sv
// Scoreboard bench for layer_reg_file: a DEPTH=32 instance plus a DEPTH=24 instance
// sharing write/clear stimulus to exercise out-of-range addresses.
module tb_layer_reg_file;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 5;
  localparam int unsigned NR  = 2;
  localparam int unsigned D24 = 24;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [DW-1:0]  wr_mask;
  logic [NR-1:0]  rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic           clr_req;
  logic           busy;
  logic           clr_done;
  logic           wr_drop;
  logic [31:0]    dirty;
  logic           dirty_clr;
  logic           dirty_any;

  logic [NR-1:0]    rd_en24;
  logic [NR*AW-1:0] rd_addr24;
  logic [NR*DW-1:0] rd_data24;
  logic             busy24, clr_done24, wr_drop24, dirty_any24;
  logic [D24-1:0]   dirty24;

  layer_reg_file u_dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop),
    .dirty(dirty), .dirty_clr(dirty_clr), .dirty_any(dirty_any)
  );

  layer_reg_file #(.DEPTH(D24)) u_d24 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en24), .rd_addr(rd_addr24), .rd_data(rd_data24),
    .clr_req(clr_req), .busy(busy24), .clr_done(clr_done24), .wr_drop(wr_drop24),
    .dirty(dirty24), .dirty_clr(dirty_clr), .dirty_any(dirty_any24)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic [NR-1:0] rd_pend = '0;
  logic [NR-1:0] rd_pend24 = '0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rd_pend   <= rd_en;
    rd_pend24 <= rd_en24;
  end

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q24[$];
  int            clr_q[$];
  int            drop_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
  endtask

  task automatic fail_unexp(input string nm, input logic [31:0] got);
    n_chk++;
    $display("FAIL %s: unexpected output %h, nothing expected (cycle %0d)", nm, got, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (rd_pend[0]) begin
      if (exp_q0.size() == 0) fail_unexp("rd0", 32'(rd_data[15:0]));
      else chk("rd0", 32'(rd_data[15:0]), 32'(exp_q0.pop_front()));
    end
    if (rd_pend[1]) begin
      if (exp_q1.size() == 0) fail_unexp("rd1", 32'(rd_data[31:16]));
      else chk("rd1", 32'(rd_data[31:16]), 32'(exp_q1.pop_front()));
    end
    if (rd_pend24[0]) begin
      if (exp_q24.size() == 0) fail_unexp("rd24", 32'(rd_data24[15:0]));
      else chk("rd24", 32'(rd_data24[15:0]), 32'(exp_q24.pop_front()));
    end
    if (clr_done) begin
      if (clr_q.size() == 0) fail_unexp("clr_done", 32'(cyc));
      else chk("clr_done_cycle", 32'(cyc), 32'(clr_q.pop_front()));
    end
    if (wr_drop) begin
      if (drop_q.size() == 0) fail_unexp("wr_drop", 32'(cyc));
      else chk("wr_drop_cycle", 32'(cyc), 32'(drop_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en     = 1'b0;
    rd_en     = '0;
    rd_en24   = '0;
    clr_req   = 1'b0;
    dirty_clr = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mask = m;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
    if (p == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic rd24(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_en24[0]     = 1'b1;
    rd_addr24[4:0] = a;
    exp_q24.push_back(e);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_en = '0; rd_addr = '0; rd_en24 = '0; rd_addr24 = '0;
    clr_req = 1'b0; dirty_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_dirty", dirty, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_clr_done", 32'(clr_done), 32'h0);
    chk("reset_wr_drop", 32'(wr_drop), 32'h0);
    reset = 1'b1;
    step();

    // Full write and read-back
    wr(5'd3, 16'hABCD, 16'hFFFF); step();
    rd(0, 5'd3, 16'hABCD); step();
    chk("dirty_after_wr3", dirty, 32'h0000_0008);
    chk("dirty_any_wr3", 32'(dirty_any), 32'h1);

    // Masked merge, then a zero-mask write
    wr(5'd5, 16'h1234, 16'hFFFF); step();
    wr(5'd5, 16'hFF00, 16'h0F0F); step();
    rd(0, 5'd5, 16'h1F30); step();
    dirty_clr = 1'b1; step();
    chk("dirty_cleared", dirty, 32'h0);
    wr(5'd5, 16'hFFFF, 16'h0000); step();
    chk("dirty_mask0", dirty, 32'h0);
    chk("dirty_any_mask0", 32'(dirty_any), 32'h0);
    rd(1, 5'd5, 16'h1F30); step();

    // Write-first bypass on both ports, then partial-mask bypass
    wr(5'd7, 16'h00AA, 16'hFFFF); rd(0, 5'd7, 16'h00AA); rd(1, 5'd7, 16'h00AA); step();
    wr(5'd7, 16'h5500, 16'hFF00); rd(1, 5'd7, 16'h55AA); step();
    step();
    chk("rd_hold", rd_data, 32'h55AA_00AA);

    // dirty_clr racing a write: the write's flag survives
    dirty_clr = 1'b1; wr(5'd9, 16'h0042, 16'hFFFF); step();
    chk("dirty_clr_vs_wr", dirty, 32'h0000_0200);
    chk("dirty_any_clr_vs_wr", 32'(dirty_any), 32'h1);
    chk("dirty24_clr_vs_wr", 32'(dirty24), 32'h0000_0200);

    // Address 30: valid on DEPTH=32, out of range on DEPTH=24
    wr(5'd30, 16'hBEEF, 16'hFFFF); rd24(5'd30, 16'h0000); step();
    chk("dirty24_oob_wr", 32'(dirty24), 32'h0000_0200);
    chk("dirty_wr30", dirty, 32'h4000_0200);
    rd(0, 5'd30, 16'hBEEF); rd24(5'd3, 16'hABCD); step();

    // Clear sweep with a write in the request cycle, reads and writes mid-sweep
    clr_req = 1'b1; wr(5'd6, 16'h6666, 16'hFFFF);
    drop_q.push_back(cyc + 1); clr_q.push_back(cyc + 33);
    step();
    for (int k = 1; k <= 32; k++) begin
      chk("busy_sweep1", 32'(busy), 32'h1);
      case (k)
        1:  rd(0, 5'd0, 16'h0000);
        2:  rd(0, 5'd3, 16'hABCD);
        4:  rd(1, 5'd3, 16'h0000);
        5:  clr_req = 1'b1;
        10: begin wr(5'd2, 16'h2222, 16'hFFFF); drop_q.push_back(cyc + 1); end
        31: rd(0, 5'd30, 16'h0000);
        32: begin wr(5'd0, 16'h1111, 16'hFFFF); drop_q.push_back(cyc + 1); end
        default: ;
      endcase
      step();
    end
    chk("busy_after_sweep1", 32'(busy), 32'h0);
    chk("dirty_after_sweep1", dirty, 32'h0);
    for (int a = 0; a < 32; a++) begin
      rd(0, AW'(a), 16'h0000); step();
    end

    // Reset asserted partway through a sweep
    wr(5'd20, 16'h7777, 16'hFFFF); step();
    clr_req = 1'b1; step();
    repeat (14) step();
    reset = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_rd_data", rd_data, 32'h0);
    chk("midreset_dirty", dirty, 32'h0);
    step();
    reset = 1'b1;
    rd(0, 5'd20, 16'h0000); step();

    // Fresh sweep after reset runs the full length
    clr_req = 1'b1; clr_q.push_back(cyc + 33); step();
    for (int k = 1; k <= 32; k++) begin
      chk("busy_sweep2", 32'(busy), 32'h1);
      step();
    end
    chk("busy_after_sweep2", 32'(busy), 32'h0);
    step();
    step();

    chk("left_rd0", 32'(exp_q0.size()), 32'h0);
    chk("left_rd1", 32'(exp_q1.size()), 32'h0);
    chk("left_rd24", 32'(exp_q24.size()), 32'h0);
    chk("left_clr_done", 32'(clr_q.size()), 32'h0);
    chk("left_wr_drop", 32'(drop_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
